// File: rtl/pid_oversample.sv
// Per-channel boxcar decimator: sums 2^os samples per channel, emits the floored mean.
// One registered cycle of latency; accepts one instruction every cycle, no backpressure.
module pid_oversample #(
  parameter int W_CHAN    = 5,
  parameter int N_CHAN    = 8,
  parameter int W_DATA    = 18,
  parameter int MAX_OS    = 8,
  parameter int W_OS      = 4,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48,
  parameter logic [W_WR_ADDR-1:0] OS_ADDR = 16'h0004
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DATA-1:0]    data_in,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DATA-1:0]    data_out
);

  localparam int W_ACC = W_DATA + MAX_OS;
  localparam int W_CNT = MAX_OS + 1;
  localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam logic [W_CHAN-1:0]    LIM_SMP = W_CHAN'(N_CHAN);
  localparam logic [W_WR_CHAN-1:0] LIM_WR  = W_WR_CHAN'(N_CHAN);
  localparam logic [W_OS-1:0]      OS_MAX  = W_OS'(MAX_OS);

  logic [W_OS-1:0]         r_os  [N_CHAN];
  logic [W_CNT-1:0]        r_cnt [N_CHAN];
  logic signed [W_ACC-1:0] r_acc [N_CHAN];
  logic                    r_dv;
  logic [W_CHAN-1:0]       r_chan;
  logic [W_DATA-1:0]       r_data;

  logic [W_IDX-1:0]        w_sidx;
  logic [W_IDX-1:0]        w_widx;
  logic                    w_wr_hit;
  logic                    w_smp_hit;
  logic                    w_smp_ok;
  logic                    w_done;
  logic [W_OS-1:0]         w_wr_os;
  logic signed [W_ACC-1:0] w_sum;
  logic signed [W_ACC-1:0] w_shift;
  logic [W_CNT-1:0]        w_n;
  logic                    w_unused;

  // Range checks happen at full width, so the truncated indices are always in bounds when used.
  assign w_sidx    = chan_in[W_IDX-1:0];
  assign w_widx    = wr_chan[W_IDX-1:0];
  assign w_wr_hit  = wr_en && (wr_addr == OS_ADDR) && (wr_chan < LIM_WR);
  assign w_smp_hit = dv_in && (chan_in < LIM_SMP);
  // A config write to the sample's own channel wins and swallows the sample.
  assign w_smp_ok  = w_smp_hit && !(w_wr_hit && (w_widx == w_sidx));
  assign w_wr_os   = (wr_data[W_OS-1:0] > OS_MAX) ? OS_MAX : wr_data[W_OS-1:0];

  assign w_sum   = r_acc[w_sidx] + $signed({{MAX_OS{data_in[W_DATA-1]}}, data_in});
  assign w_n     = r_cnt[w_sidx] + W_CNT'(1);
  assign w_done  = (w_n == (W_CNT'(1) << r_os[w_sidx]));
  assign w_shift = w_sum >>> r_os[w_sidx];

  assign w_unused = &{1'b0, wr_data[W_WR_DATA-1:W_OS], w_shift[W_ACC-1:W_DATA]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_CHAN; i++) begin
        r_os[i]  <= '0;
        r_cnt[i] <= '0;
        r_acc[i] <= '0;
      end
      r_dv   <= 1'b0;
      r_chan <= '0;
      r_data <= '0;
    end else begin
      r_dv <= 1'b0;
      if (w_smp_ok) begin
        if (w_done) begin
          r_dv          <= 1'b1;
          r_chan        <= chan_in;
          r_data        <= w_shift[W_DATA-1:0];
          r_acc[w_sidx] <= '0;
          r_cnt[w_sidx] <= '0;
        end else begin
          r_acc[w_sidx] <= w_sum;
          r_cnt[w_sidx] <= w_n;
        end
      end
      if (w_wr_hit) begin
        r_os[w_widx]  <= w_wr_os;
        r_acc[w_widx] <= '0;
        r_cnt[w_widx] <= '0;
      end
    end
  end

  assign dv_out   = r_dv;
  assign chan_out = r_chan;
  assign data_out = r_data;

endmodule

// File: tb/tb_pid_oversample.sv
// Directed and randomized bench for pid_oversample against a windowed-mean reference model.
module tb_pid_oversample;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        dv_in;
  logic [4:0]  chan_in;
  logic [17:0] data_in;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_chan;
  logic [47:0] wr_data;
  logic        dv_out;
  logic [4:0]  chan_out;
  logic [17:0] data_out;

  int checks = 0;
  int errors = 0;

  // reference model: programmed ratio, samples seen and their running total per channel
  int     m_os  [8];
  int     m_seen[8];
  longint m_tot [8];
  logic        exp_dv;
  logic [4:0]  exp_chan;
  logic [17:0] exp_data;

  pid_oversample dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .dv_in   (dv_in),
    .chan_in (chan_in),
    .data_in (data_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_chan (wr_chan),
    .wr_data (wr_data),
    .dv_out  (dv_out),
    .chan_out(chan_out),
    .data_out(data_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic longint floor_mean(input longint total, input int k);
    longint d;
    longint q;
    d = longint'(1) << k;
    q = total / d;
    if ((total % d) != 0 && total < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic dv, input logic [4:0] ch, input logic [17:0] d,
                       input logic wr, input logic [15:0] wa, input logic [15:0] wc,
                       input logic [47:0] wd, input string tag);
    bit     wr_hit;
    bit     smp_hit;
    int     c;
    longint v;
    rst_in = rst; dv_in = dv; chan_in = ch; data_in = d;
    wr_en = wr; wr_addr = wa; wr_chan = wc; wr_data = wd;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_os[i] = 0; m_seen[i] = 0; m_tot[i] = 0;
      end
      exp_dv = 1'b0; exp_chan = '0; exp_data = '0;
    end else begin
      wr_hit  = wr && (wa == 16'h0004) && (wc < 16'd8);
      smp_hit = dv && (ch < 5'd8);
      exp_dv  = 1'b0;
      if (smp_hit && !(wr_hit && (wc == 16'(ch)))) begin
        c = int'(ch);
        v = longint'($signed(d));
        m_tot[c] += v;
        m_seen[c]++;
        if (m_seen[c] == (1 << m_os[c])) begin
          exp_dv   = 1'b1;
          exp_chan = ch;
          exp_data = 18'(floor_mean(m_tot[c], m_os[c]));
          m_tot[c] = 0; m_seen[c] = 0;
        end
      end
      if (wr_hit) begin
        c = int'(wc);
        m_os[c]   = (int'(wd[3:0]) > 8) ? 8 : int'(wd[3:0]);
        m_tot[c]  = 0;
        m_seen[c] = 0;
      end
    end
    @(posedge clk_in);
    #1;
    chk({tag, "_dv"},   32'(dv_out),   32'(exp_dv));
    chk({tag, "_chan"}, 32'(chan_out), 32'(exp_chan));
    chk({tag, "_data"}, 32'(data_out), 32'(exp_data));
  endtask

  task automatic smp(input logic [4:0] ch, input logic [17:0] d, input string tag);
    drive(1'b0, 1'b1, ch, d, 1'b0, 16'h0, 16'h0, 48'h0, tag);
  endtask

  task automatic cfg(input logic [15:0] ch, input logic [47:0] os, input string tag);
    drive(1'b0, 1'b0, 5'd0, 18'd0, 1'b1, 16'h0004, ch, os, tag);
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 18'd0, 1'b0, 16'h0, 16'h0, 48'h0, "rst0");
    drive(1'b1, 1'b1, 5'd3, 18'h5, 1'b1, 16'h0004, 16'd3, 48'h2, "rst1");

    smp(5'd3, 18'h12345, "pass");
    chk("pass_const", 32'(data_out), 32'h12345);

    cfg(16'd2, 48'd2, "cfg2");
    smp(5'd2, 18'd10, "avg_a");
    smp(5'd2, 18'd11, "avg_b");
    smp(5'd2, 18'd12, "avg_c");
    smp(5'd2, 18'd14, "avg_d");
    chk("avg_const", 32'(data_out), 32'd11);

    cfg(16'd0, 48'd1, "cfg0");
    smp(5'd0, 18'h3FFFD, "neg_a");
    smp(5'd0, 18'h3FFFC, "neg_b");
    chk("neg_const", 32'(data_out), 32'h3FFFC);

    cfg(16'd0, 48'd8, "cfg0max");
    for (int i = 0; i < 256; i++) smp(5'd0, 18'h1FFFF, "full");
    chk("full_const", 32'(data_out), 32'h1FFFF);

    cfg(16'd7, 48'd15, "clamp_cfg");
    for (int i = 0; i < 256; i++) smp(5'd7, 18'($urandom), "clamp");
    chk("clamp_dv_const", 32'(dv_out), 32'd1);

    cfg(16'd1, 48'd1, "cfg1");
    cfg(16'd5, 48'd1, "cfg5");
    smp(5'd1, 18'd4,   "il_a");
    smp(5'd5, 18'd100, "il_b");
    smp(5'd1, 18'd6,   "il_c");
    chk("il_c_const", 32'(data_out), 32'd5);
    smp(5'd5, 18'd200, "il_d");
    chk("il_d_const", 32'(data_out), 32'd150);

    cfg(16'd4, 48'd2, "cfg4");
    smp(5'd4, 18'd1, "col_a");
    smp(5'd4, 18'd2, "col_b");
    drive(1'b0, 1'b1, 5'd4, 18'd99, 1'b1, 16'h0004, 16'd4, 48'd2, "col_hit");
    smp(5'd4, 18'd8,  "col_c");
    smp(5'd4, 18'd9,  "col_d");
    smp(5'd4, 18'd10, "col_e");
    smp(5'd4, 18'd11, "col_f");
    chk("col_const", 32'(data_out), 32'd9);

    drive(1'b0, 1'b0, 5'd0, 18'd0, 1'b1, 16'h0004, 16'd9, 48'd3, "wr_ch9");
    drive(1'b0, 1'b0, 5'd0, 18'd0, 1'b1, 16'h0008, 16'd3, 48'd2, "wr_badaddr");
    smp(5'd3, 18'd77, "after_bad");
    smp(5'd9, 18'd55, "ch9");

    cfg(16'd6, 48'd3, "cfg6");
    for (int i = 0; i < 5; i++) smp(5'd6, 18'(i + 1), "mid");
    drive(1'b1, 1'b1, 5'd6, 18'd6, 1'b0, 16'h0, 16'h0, 48'h0, "rst_mid");
    smp(5'd6, 18'h00777, "post_rst");
    chk("post_rst_const", 32'(data_out), 32'h777);

    for (int i = 0; i < 2000; i++) begin
      logic [47:0] wd;
      wd = ($urandom_range(0, 9) == 0) ? 48'(15) : 48'($urandom_range(0, 3));
      wd[47:4] = 44'($urandom);
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 9) < 8),
            5'($urandom_range(0, 9)),
            18'($urandom),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0) ? 16'h0008 : 16'h0004,
            16'($urandom_range(0, 9)),
            wd,
            "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
